// File: rtl/chan_arbiter.sv
// chan_arbiter: round-robin merge of per-channel trigger blocks into one
// 16-bit stream. A granted channel is drained for exactly one block, whose
// length comes from its header, before the grant moves on.
module chan_arbiter #(
  parameter int NCH = 16,
  parameter int CW  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [16*NCH-1:0] chan_data,
  input  logic [NCH-1:0]    chan_req,
  output logic [NCH-1:0]    chan_ack,
  input  logic [NCH-1:0]    chan_en,
  output logic [15:0]       odata,
  output logic              ovalid,
  input  logic              oready,
  output logic              osop,
  output logic              oeop,
  output logic              busy,
  output logic              hdr_err,
  output logic [CW-1:0]     gnt_ch
);

  typedef enum logic [1:0] {IDLE, CAPT, W1, W2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   gnt_q, gnt_d;
  logic [8:0]      rem_q, rem_d;
  logic            first_q, first_d;
  logic [15:0]     odata_q, odata_d;
  logic            ovalid_q, ovalid_d;
  logic            osop_q, osop_d;
  logic            oeop_q, oeop_d;
  logic            busy_q, busy_d;
  logic            hdr_err_q, hdr_err_d;

  logic [15:0]     sel_word;
  logic [NCH-1:0]  cand;
  logic            found;
  logic [CW-1:0]   pick;
  logic            load;
  logic [NCH-1:0]  ack_c;
  logic [8:0]      rem_new;
  logic            last;

  // Word currently presented by the granted channel.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt_q == CW'(i)) sel_word = chan_data[16*i +: 16];
  end

  // First enabled requester searching upward from ptr, wrapping at NCH.
  always_comb begin
    int idx;
    idx   = 0;
    cand  = chan_req & chan_en;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  // Next-state logic: grant, word capture, block length tracking.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    rem_d     = rem_q;
    first_d   = first_q;
    odata_d   = odata_q;
    ovalid_d  = ovalid_q;
    osop_d    = osop_q;
    oeop_d    = oeop_q;
    busy_d    = busy_q;
    hdr_err_d = 1'b0;
    ack_c     = '0;
    rem_new   = rem_q;
    last      = 1'b0;
    // The output register is free when empty or being drained this cycle;
    // this is the only place oready reaches chan_ack.
    load = (state_q == CAPT) && (!ovalid_q || oready);

    if (ovalid_q && oready) begin
      ovalid_d = 1'b0;
      osop_d   = 1'b0;
      oeop_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          busy_d  = 1'b1;
          first_d = 1'b1;
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (load) begin
          ack_c    = NCH'(1) << gnt_q;
          odata_d  = sel_word;
          ovalid_d = 1'b1;
          osop_d   = first_q;
          first_d  = 1'b0;
          if (first_q) begin
            if (!sel_word[15]) begin
              // Malformed header: pass it on as a one-word block.
              hdr_err_d = 1'b1;
              rem_new   = '0;
            end else begin
              // size-1: L for self trigger, L+1 for master trigger.
              rem_new = {1'b0, sel_word[7:0]} + {8'd0, sel_word[14]};
            end
          end else begin
            rem_new = rem_q - 9'd1;
          end
          last    = (rem_new == 9'd0);
          rem_d   = rem_new;
          oeop_d  = last;
          if (last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ptr_d   = (gnt_q == CW'(NCH-1)) ? '0 : gnt_q + CW'(1);
          end else begin
            state_d = W1;
          end
        end
      end
      // Two idle cycles cover the channel's ack-to-new-dout latency.
      W1: state_d = W2;
      W2: state_d = CAPT;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
      osop_q    <= 1'b0;
      oeop_q    <= 1'b0;
      busy_q    <= 1'b0;
      hdr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
      osop_q    <= osop_d;
      oeop_q    <= oeop_d;
      busy_q    <= busy_d;
      hdr_err_q <= hdr_err_d;
    end
  end

  assign chan_ack = ack_c;
  assign odata    = odata_q;
  assign ovalid   = ovalid_q;
  assign osop     = osop_q;
  assign oeop     = oeop_q;
  assign busy     = busy_q;
  assign hdr_err  = hdr_err_q;
  assign gnt_ch   = gnt_q;

endmodule
